perceptron_layer_sched: RTL and testbench

- Time-multiplexes one shared combinational perceptron datapath (2 inputs, 2 weights, 1 bias → activation a, pre-activation z) across NEURONS neurons of one layer.
- Holds per-neuron weights/bias in an internal register file loaded through a config port.
- On a start handshake, latches the two layer inputs and steps the neuron index, one neuron per cycle.
- Streams each neuron's (a, z) result out on a valid/ready interface, then pulses done.

---
 rtl/perceptron_layer_sched.sv | 152 +++++++++++++++
 tb/tb_perceptron_layer_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_layer_sched.sv
// Time-multiplexes one external perceptron datapath across NEURONS neurons of a layer,
// holding per-neuron weights/bias locally and streaming (idx, a, z) over valid/ready.
module perceptron_layer_sched #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NEURONS = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic [1:0]       i_cfg_sel,
    input  logic [WIDTH-1:0] i_cfg_data,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_k0,
    input  logic [WIDTH-1:0] i_k1,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_p_k0,
    output logic [WIDTH-1:0] o_p_k1,
    output logic [WIDTH-1:0] o_p_w0,
    output logic [WIDTH-1:0] o_p_w1,
    output logic [WIDTH-1:0] o_p_bias,
    input  logic [WIDTH-1:0] i_p_a,
    input  logic [WIDTH-1:0] i_p_z,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_z,
    input  logic             i_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] w0_q   [NEURONS];
    logic [WIDTH-1:0] w1_q   [NEURONS];
    logic [WIDTH-1:0] bias_q [NEURONS];
    logic [WIDTH-1:0] k0_q, k1_q;
    logic [IDX_W-1:0] cnt_q;
    logic             busy_q, done_q, valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, z_q;
    logic [WIDTH-1:0] w0_sel, w1_sel, bias_sel;
    logic             cap;

    // Register file; writes only land while no pass is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NEURONS); i++) begin
                w0_q[i]   <= '0;
                w1_q[i]   <= '0;
                bias_q[i] <= '0;
            end
        end else if (i_cfg_we && state_q == S_IDLE) begin
            for (int i = 0; i < int'(NEURONS); i++) begin
                if (i_cfg_idx == IDX_W'(i)) begin
                    case (i_cfg_sel)
                        2'd0:    w0_q[i]   <= i_cfg_data;
                        2'd1:    w1_q[i]   <= i_cfg_data;
                        2'd2:    bias_q[i] <= i_cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Entry select by the registered counter; out-of-range counter values read as zero.
    always_comb begin
        w0_sel   = '0;
        w1_sel   = '0;
        bias_sel = '0;
        for (int i = 0; i < int'(NEURONS); i++) begin
            if (cnt_q == IDX_W'(i)) begin
                w0_sel   = w0_q[i];
                w1_sel   = w1_q[i];
                bias_sel = bias_q[i];
            end
        end
    end

    assign cap = !valid_q || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            z_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        k0_q    <= i_k0;
                        k1_q    <= i_k1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cap) begin
                        a_q     <= i_p_a;
                        z_q     <= i_p_z;
                        idx_q   <= cnt_q;
                        valid_q <= 1'b1;
                        if (cnt_q == IDX_W'(NEURONS - 1)) begin
                            state_q <= S_LAST;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                S_LAST: begin
                    // Final result drains; busy drops as done rises.
                    if (valid_q && i_ready) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_p_k0   = k0_q;
    assign o_p_k1   = k1_q;
    assign o_p_w0   = w0_sel;
    assign o_p_w1   = w1_sel;
    assign o_p_bias = bias_sel;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_valid  = valid_q;
    assign o_idx    = idx_q;
    assign o_a      = a_q;
    assign o_z      = z_q;

endmodule

// File: tb/tb_perceptron_layer_sched.sv
// Randomized bench for perceptron_layer_sched with a stub perceptron and a queue-based model.
module tb_perceptron_layer_sched;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 3;

    logic          clk, rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [1:0]    cfg_sel;
    logic [W-1:0]  cfg_data;
    logic          start;
    logic [W-1:0]  k0, k1;
    logic          busy, done, valid, ready;
    logic [W-1:0]  p_k0, p_k1, p_w0, p_w1, p_bias, p_a, p_z;
    logic [IW-1:0] idx;
    logic [W-1:0]  a, z;

    perceptron_layer_sched #(.WIDTH(W), .NEURONS(N), .IDX_W(IW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
        .i_start(start), .i_k0(k0), .i_k1(k1),
        .o_busy(busy), .o_done(done),
        .o_p_k0(p_k0), .o_p_k1(p_k1), .o_p_w0(p_w0), .o_p_w1(p_w1), .o_p_bias(p_bias),
        .i_p_a(p_a), .i_p_z(p_z),
        .o_valid(valid), .o_idx(idx), .o_a(a), .o_z(z), .i_ready(ready)
    );

    // Stub perceptron.
    assign p_z = p_bias + p_k0;
    assign p_a = p_w0 + p_k1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Behavioural model state.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] a;
        logic [31:0] z;
    } res_t;

    res_t        expq[$];
    res_t        r;
    logic [31:0] mw0 [N];
    logic [31:0] mw1 [N];
    logic [31:0] mb  [N];
    bit          busy_exp, valid_exp, done_exp, arm, cur_busy, final_x;
    bit          stall_prev;
    logic [31:0] h_idx, h_a, h_z;
    int          log_n, busy_cnt;
    logic [31:0] log_idx [64];
    logic [31:0] log_a   [64];
    logic [31:0] log_z   [64];

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            mw0[i] = '0; mw1[i] = '0; mb[i] = '0;
        end
        busy_exp = 0; valid_exp = 0; done_exp = 0; arm = 0; stall_prev = 0;
        log_n = 0; busy_cnt = 0;
    end

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            for (int i = 0; i < int'(N); i++) begin
                mw0[i] = '0; mw1[i] = '0; mb[i] = '0;
            end
            busy_exp = 0; valid_exp = 0; done_exp = 0; arm = 0; stall_prev = 0;
        end else begin
            check("busy", 32'(busy), 32'(busy_exp));
            check("valid", 32'(valid), 32'(valid_exp));
            check("done", 32'(done), 32'(done_exp));
            if (stall_prev) begin
                check("hold_idx", 32'(idx), h_idx);
                check("hold_a", a, h_a);
                check("hold_z", z, h_z);
            end
            if (busy) busy_cnt++;
            final_x  = 0;
            cur_busy = busy_exp;
            if (valid && ready) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_result: got idx %0d want none", idx);
                end else begin
                    r = expq.pop_front();
                    check("res_idx", 32'(idx), r.idx);
                    check("res_a", a, r.a);
                    check("res_z", z, r.z);
                    final_x = (r.idx == 32'(N - 1));
                end
                if (log_n < 64) begin
                    log_idx[log_n] = 32'(idx); log_a[log_n] = a; log_z[log_n] = z;
                end
                log_n++;
            end
            done_exp = final_x;
            if (arm) begin
                valid_exp = 1;
                arm = 0;
            end
            if (final_x) begin
                busy_exp = 0; valid_exp = 0;
            end
            if (cfg_we && !cur_busy && cfg_idx < IW'(N) && cfg_sel != 2'd3) begin
                case (cfg_sel)
                    2'd0:    mw0[cfg_idx] = cfg_data;
                    2'd1:    mw1[cfg_idx] = cfg_data;
                    default: mb[cfg_idx]  = cfg_data;
                endcase
            end
            if (start && !cur_busy) begin
                for (int i = 0; i < int'(N); i++) begin
                    r.idx = 32'(i);
                    r.a   = mw0[i] + k1;
                    r.z   = mb[i] + k0;
                    expq.push_back(r);
                end
                busy_exp = 1; valid_exp = 0; arm = 1;
            end
            stall_prev = valid && !ready;
            h_idx = 32'(idx); h_a = a; h_z = z;
        end
    end

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random.
    int         rdy_mode = 0;
    int         pi = 0;
    logic [5:0] rdy_pat = 6'b101001;
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       ready = 1'b1;
                1:       begin ready = rdy_pat[pi]; pi = (pi + 1) % 6; end
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_n = 0; busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            log_idx[i] = 32'hdead; log_a[i] = 32'hdead; log_z[i] = 32'hdead;
        end
    endtask

    task automatic cfg_write(input logic [IW-1:0] ci, input logic [1:0] cs, input logic [31:0] cd);
        cfg_we = 1'b1; cfg_idx = ci; cfg_sel = cs; cfg_data = cd;
        tick();
        cfg_we = 1'b0;
    endtask

    // mode 0: quiet, 1: busy cfg write + extra start, 2: random noise. Returns in the done cycle.
    task automatic run_pass(input logic [31:0] pk0, input logic [31:0] pk1, input int mode);
        int n;
        k0 = pk0; k1 = pk1; start = 1'b1;
        tick();
        start = 1'b0; cfg_we = 1'b0; k0 = $urandom; k1 = $urandom;
        n = 0;
        while (!done && n < 200) begin
            if (mode == 1) begin
                cfg_we = (n == 0); cfg_idx = 3'd1; cfg_sel = 2'd0; cfg_data = 32'd100;
                start  = (n == 1);
            end else if (mode == 2) begin
                cfg_we = 1'($urandom_range(0, 1)); cfg_idx = IW'($urandom_range(0, 7));
                cfg_sel = 2'($urandom_range(0, 3)); cfg_data = $urandom;
                start = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        cfg_we = 1'b0; start = 1'b0;
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL pass_timeout: got no done want done within 200 cycles");
        end
    endtask

    task automatic check_log(input string tag, input int ia [4], input int iz [4]);
        check({tag, "_count"}, 32'(log_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_idx"}, log_idx[i], 32'(i));
            check({tag, "_a"}, log_a[i], 32'(ia[i]));
            check({tag, "_z"}, log_z[i], 32'(iz[i]));
        end
    endtask

    initial begin
        int la [4];
        int lz [4];
        int n;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
        start = 1'b0; k0 = '0; k1 = '0;
        clear_log();
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_idx", 32'(idx), 0);
        check("rst_a", a, 0);
        check("rst_z", z, 0);
        check("rst_w0", p_w0, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            cfg_write(IW'(i), 2'd0, 32'(i + 1));
            cfg_write(IW'(i), 2'd2, 32'(10 * (i + 1)));
            cfg_write(IW'(i), 2'd1, $urandom);
        end

        // Back-to-back pass with ready held high.
        clear_log(); rdy_mode = 0;
        run_pass(5, 7, 0);
        la = '{8, 9, 10, 11}; lz = '{15, 25, 35, 45};
        check_log("p1", la, lz);
        check("p1_busy_cycles", 32'(busy_cnt), 32'd5);

        // Same pass with ready toggling.
        tick(); clear_log(); rdy_mode = 1;
        run_pass(5, 7, 0);
        check_log("p2", la, lz);
        rdy_mode = 0;

        // Busy-time cfg write and extra start are ignored.
        tick(); tick(); clear_log();
        run_pass(5, 7, 1);
        check_log("p3", la, lz);

        // Cfg write together with start applies to this pass.
        tick(); clear_log();
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_sel = 2'd0; cfg_data = 32'd100;
        run_pass(5, 7, 0);
        la = '{8, 107, 10, 11};
        check_log("p4", la, lz);

        // Start in the done cycle is accepted.
        clear_log();
        run_pass(1, 2, 0);
        la = '{3, 102, 5, 6}; lz = '{11, 21, 31, 41};
        check_log("p5", la, lz);

        // Ignored writes: sel=3, out-of-range index.
        tick();
        cfg_write(3'd1, 2'd3, 32'd999);
        cfg_write(3'd5, 2'd0, 32'd777);
        cfg_write(3'd7, 2'd2, 32'd555);
        clear_log();
        run_pass(5, 7, 0);
        la = '{8, 107, 10, 11}; lz = '{15, 25, 35, 45};
        check_log("p6", la, lz);

        // Randomized passes with random ready, config and start noise.
        rdy_mode = 2;
        for (int p = 0; p < 8; p++) begin
            repeat ($urandom_range(0, 3)) begin
                cfg_write(IW'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
            end
            clear_log();
            run_pass($urandom, $urandom, 2);
            check("rnd_count", 32'(log_n), 32'd4);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Reset in the middle of a pass.
        rdy_mode = 0; tick(); tick(); clear_log();
        k0 = 5; k1 = 7; start = 1'b1;
        tick();
        start = 1'b0; n = 0;
        while (log_n < 2 && n < 50) begin tick(); n++; end
        check("mid_results", 32'(log_n), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_w0", p_w0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        clear_log();
        run_pass(11, 22, 0);
        la = '{22, 22, 22, 22}; lz = '{11, 11, 11, 11};
        check_log("post_rst", la, lz);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500000");
        $fatal(1);
    end

endmodule
